// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for an NDIG-digit 7-segment display, with frame-aligned word commits.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg_scan_driver #(
  parameter int NDIG  = 8,
  parameter int DIV   = 50000,
  parameter int BLANK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NDIG-1:0]       load_data,
  output logic [3:0]              bcd,
  output logic [NDIG-1:0]         dig_sel,
  output logic [$clog2(NDIG)-1:0] scan_idx,
  output logic                    frame_done
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [4*NDIG-1:0] cur, cur_n, pend;
  logic              pend_v;
  logic              commit, wrap, lit;
  logic [3:0]        bcd_n;
  logic [NDIG-1:0]   dig_sel_n;

  assign load_ready = ~pend_v;
  assign scan_idx   = idx;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    commit  = 1'b0;
    wrap    = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_BLANK;
          cnt_n   = '0;
          idx_n   = '0;
          commit  = pend_v;
        end
        S_BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_n = S_SHOW;
        end
        S_SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = S_BLANK;
            if (idx == IDX_LAST) begin
              idx_n  = '0;
              wrap   = 1'b1;
              commit = pend_v;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    cur_n = commit ? pend : cur;
  end

`ifdef LEADING_ZERO_BLANK_EN
  // hi_zero[i] is set when digit i and every digit above it are zero.
  logic [NDIG-1:0] hi_zero;
  always_comb begin
    hi_zero           = '1;
    hi_zero[NDIG-1]   = (cur_n[4*NDIG-1 -: 4] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--)
      hi_zero[i] = hi_zero[i+1] && (cur_n[4*i +: 4] == 4'd0);
  end
`endif

  // Outputs are decoded from next-state values so the registers line up with the state they describe.
  always_comb begin
    lit = (state_n == S_SHOW);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_n != '0 && hi_zero[idx_n]) lit = 1'b0;
`endif
    bcd_n     = lit ? cur_n[4*idx_n +: 4] : 4'hF;
    dig_sel_n = lit ? ~(NDIG'(1) << idx_n) : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      cur        <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      bcd        <= 4'hF;
      dig_sel    <= '1;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of order.
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      cur        <= cur_n;
      bcd        <= bcd_n;
      dig_sel    <= dig_sel_n;
      frame_done <= wrap;
      // A commit needs pend_v=1 and a transfer needs pend_v=0, so these never collide.
      if (commit) pend_v <= 1'b0;
      if (load_valid && !pend_v) begin
        pend   <= load_data;
        pend_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (NDIG=4, DIV=8, BLANK=2) against a frame-time reference model.
module tb_seg_scan_driver;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  bcd;
  logic [3:0]  dig_sel;
  logic [1:0]  scan_idx;
  logic        frame_done;
  logic [11:0] got;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .bcd(bcd), .dig_sel(dig_sel), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign got = {bcd, dig_sel, scan_idx, frame_done, load_ready};

  // Reference model: time since scanning began, displayed word, pending word.
  logic        m_on, m_pv, m_fd;
  int          m_t;
  logic [15:0] m_cur, m_pend;
  logic [15:0] src_q[$];

  function automatic void model_reset();
    m_on = 1'b0; m_pv = 1'b0; m_fd = 1'b0; m_t = 0; m_cur = '0; m_pend = '0;
  endfunction

  function automatic void model_edge(input logic en_s, input logic xfer, input logic [15:0] d);
    logic commit;
    commit = 1'b0;
    m_fd   = 1'b0;
    if (!en_s) begin
      m_on = 1'b0;
      m_t  = 0;
    end else if (!m_on) begin
      m_on   = 1'b1;
      m_t    = 0;
      commit = m_pv;
    end else begin
      m_t = (m_t + 1) % FRAME;
      if (m_t == 0) begin
        m_fd   = 1'b1;
        commit = m_pv;
      end
    end
    if (commit) begin
      m_cur = m_pend;
      m_pv  = 1'b0;
    end
    if (xfer) begin
      m_pend = d;
      m_pv   = 1'b1;
    end
  endfunction

  function automatic logic [11:0] model_out();
    int         slot;
    logic       lit;
    logic [3:0] b, d;
    slot = m_on ? m_t / DIV : 0;
    lit  = m_on && (m_t % DIV) >= BLANK;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (m_cur >> (4 * slot)) == 16'd0) lit = 1'b0;
`endif
    b = lit ? m_cur[4*slot +: 4] : 4'hF;
    d = lit ? ~(4'b0001 << slot) : 4'hF;
    return {b, d, 2'(slot), m_fd, ~m_pv};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int          r;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      w[4*i +: 4] = 4'd0;
      else if (r < 9) w[4*i +: 4] = 4'($urandom_range(1, 9));
      else            w[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return w;
  endfunction

  task automatic push(input logic [15:0] w);
    src_q.push_back(w);
    load_valid = 1'b1;
    load_data  = src_q[0];
  endtask

  // Producer holds valid/data until the transfer edge, then presents the next queued word.
  task automatic tick();
    logic xfer;
    xfer = load_valid && !m_pv;
    @(posedge clk);
    model_edge(en, xfer, load_data);
    if (xfer) void'(src_q.pop_front());
    @(negedge clk);
    load_valid = (src_q.size() != 0);
    if (src_q.size() != 0) load_data = src_q[0];
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (got !== 12'hFF1) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", got, 12'hFF1);
    end
    push(16'h1111);
    en = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL reset_pre t=%0t got=%h exp=%h", $time, got, model_out());
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (dig_sel !== 4'hF) begin bad++; $display("FAIL reset_dig got=%h exp=f", dig_sel); end
    total++;
    if (bcd !== 4'hF) begin bad++; $display("FAIL reset_bcd got=%h exp=f", bcd); end
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    total++;
    if (scan_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", scan_idx); end
    src_q.delete();
    load_valid = 1'b0;
    en         = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, got, model_out());
      end
    end
  endtask

  task automatic test_basic_frame();
    int         fd_cnt, fd_at;
    logic [3:0] ed, eb;
    push(16'h1234);
    tick();
    tick();
    total++;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL basic_pend_ready got=%b exp=0", load_ready); end
    en = 1'b1;
    fd_cnt = 0; fd_at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL basic cyc=%0d got=%h exp=%h", i, got, model_out());
      end
      if (frame_done === 1'b1) begin fd_cnt++; fd_at = i; end
      if (i < 32) begin
        if ((i % DIV) < BLANK) begin ed = 4'hF; eb = 4'hF; end
        else begin
          case (i / DIV)
            0:       begin ed = 4'b1110; eb = 4'd4; end
            1:       begin ed = 4'b1101; eb = 4'd3; end
            2:       begin ed = 4'b1011; eb = 4'd2; end
            default: begin ed = 4'b0111; eb = 4'd1; end
          endcase
        end
        total++;
        if (dig_sel !== ed || bcd !== eb) begin
          bad++; $display("FAIL basic_slot cyc=%0d got=%h/%h exp=%h/%h", i, dig_sel, bcd, ed, eb);
        end
      end
    end
    total++;
    if (fd_cnt != 1 || fd_at != 32) begin
      bad++; $display("FAIL basic_frame_done count=%0d at=%0d exp count=1 at=32", fd_cnt, fd_at);
    end
  endtask

  task automatic test_midframe_load();
    logic seen;
    push(16'h5678);
    tick();
    total++;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_after_accept got=%b exp=0", load_ready); end
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL mid t=%0t got=%h exp=%h", $time, got, model_out());
      end
      if (frame_done === 1'b1) seen = 1'b1;
      else if (bcd !== 4'hF) begin
        total++;
        if (bcd > 4'd4) begin bad++; $display("FAIL mid_old_word got=%h exp<=4", bcd); end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_wrap_timeout got=0 exp=1"); end
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after_wrap got=%b exp=1", load_ready); end
    repeat (BLANK) tick();
    total++;
    if (bcd !== 4'd8 || dig_sel !== 4'b1110) begin
      bad++; $display("FAIL mid_new_word got=%h/%h exp=8/e", bcd, dig_sel);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq[$];
    push(16'hAAAA);
    push(16'h9999);
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL b2b t=%0t got=%h exp=%h", $time, got, model_out());
      end
      if (i == 0) begin
        total++;
        if (load_ready !== 1'b0 || load_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_stall ready=%b valid=%b exp ready=0 valid=1", load_ready, load_valid);
        end
      end
      if (dig_sel === 4'b1110 && (seq.size() == 0 || seq[$] !== bcd)) seq.push_back(bcd);
    end
    total++;
    if (seq.size() != 3 || seq[0] !== 4'h8 || seq[1] !== 4'hA || seq[2] !== 4'h9) begin
      bad++; $display("FAIL b2b_order got size=%0d exp=8,a,9", seq.size());
    end
  endtask

  task automatic test_en_drop();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL endrop_pre t=%0t got=%h exp=%h", $time, got, model_out());
      end
      if (scan_idx === 2'd2 && dig_sel !== 4'hF) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL endrop_find_slot2 got=0 exp=1"); end
    push(16'h4321);
    tick();
    en = 1'b0;
    tick();
    total++;
    if (dig_sel !== 4'hF || bcd !== 4'hF || scan_idx !== 2'd0 || load_ready !== 1'b0) begin
      bad++; $display("FAIL endrop_off got=%h exp=ff00 pending", got);
    end
    repeat (3) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL endrop_idle t=%0t got=%h exp=%h", $time, got, model_out());
      end
    end
    en = 1'b1;
    tick();
    total++;
    if (dig_sel !== 4'hF || scan_idx !== 2'd0 || load_ready !== 1'b1) begin
      bad++; $display("FAIL endrop_restart got=%h exp=blank slot0 ready", got);
    end
    repeat (BLANK) tick();
    total++;
    if (bcd !== 4'd1 || dig_sel !== 4'b1110) begin
      bad++; $display("FAIL endrop_commit got=%h/%h exp=1/e", bcd, dig_sel);
    end
  endtask

  task automatic run_zero_word(input logic [15:0] w, input logic [15:0] exp_b, input logic [3:0] exp_lit);
    logic       seen;
    logic [3:0] ed;
    seen = load_ready;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      seen = load_ready;
    end
    push(w);
    tick();
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL zero_wait t=%0t got=%h exp=%h", $time, got, model_out());
      end
      if (frame_done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL zero_wrap_timeout got=0 exp=1"); end
    for (int s = 0; s < NDIG; s++) begin
      repeat (s == 0 ? BLANK : DIV) tick();
      ed = exp_lit[s] ? ~(4'b0001 << s) : 4'hF;
      total++;
      if (bcd !== exp_b[4*s +: 4] || dig_sel !== ed) begin
        bad++; $display("FAIL zero_slot word=%h slot=%0d got=%h/%h exp=%h/%h",
                        w, s, bcd, dig_sel, exp_b[4*s +: 4], ed);
      end
    end
  endtask

  task automatic test_zero_digits();
`ifdef LEADING_ZERO_BLANK_EN
    run_zero_word(16'h0050, 16'hFF50, 4'b0011);
    run_zero_word(16'h0000, 16'hFFF0, 4'b0001);
`else
    run_zero_word(16'h0050, 16'h0050, 4'b1111);
    run_zero_word(16'h0000, 16'h0000, 4'b1111);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if (en && $urandom_range(0, 59) == 0)       en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0)  en = 1'b1;
      if (src_q.size() == 0 && $urandom_range(0, 9) == 0) push(rand_word());
      tick();
      total++;
      if (got !== model_out()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_midframe_load();
    test_back_to_back();
    test_en_drop();
    test_zero_digits();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scanner for an NDIG-digit 7-segment display.
- Holds a packed BCD word and presents one 4-bit digit at a time on `bcd`, which feeds the BCD-to-segment decoder (active-low segments; codes above 9 decode to all-off).
- Drives active-low one-hot digit enables.
- Accepts new display words through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- NDIG, 8: number of digits; packed input width is 4*NDIG. Range 2..16.
- DIV, 50000: clock cycles per digit slot. Must satisfy DIV > BLANK.
- BLANK, 4: cycles at the start of each slot with all digits off (anti-ghosting). Must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; 0 forces display off.
- load_valid  in  1  new display word offered.
- load_ready  out  1  driver can accept a word.
- load_data  in  4*NDIG  packed BCD; digit i = load_data[4*i+3:4*i], digit 0 rightmost.
- bcd  out  4  current digit code to decoder; 4'hF when blank.
- dig_sel  out  NDIG  active-low one-hot digit enable.
- scan_idx  out  clog2(NDIG)  index of current slot.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Registers:
  - cur: displayed word.
  - pend: pending word, with flag pend_v.
  - cnt: slot counter, 0..DIV-1.
  - idx: current digit.
  - state: one of IDLE, BLANK, SHOW.
- All outputs decode from registers only; there is no combinational path from any input to any output.
- Reset (async, takes effect immediately, including mid-frame):
  - cur=0, pend=0, pend_v=0, idx=0, cnt=0, state=IDLE.
  - Outputs: bcd=4'hF, dig_sel all 1, scan_idx=0, frame_done=0, load_ready=1.
- Handshake:
  - load_ready = ~pend_v.
  - A transfer occurs on a cycle with load_valid && load_ready; pend<=load_data and pend_v<=1 on that edge.
  - The producer holds load_valid/load_data until a transfer occurs.
- Commit: cur<=pend and pend_v<=0 on the IDLE→BLANK transition and on each frame wrap, only if pend_v=1. load_ready rises on the cycle after commit.
- Simultaneous load and commit cannot conflict:
  - A commit happens only when pend_v=1, which holds load_ready at 0.
  - A load accepted on a wrap cycle while pend_v=0 is committed at the following wrap.
- IDLE: outputs off (bcd=4'hF, dig_sel all 1). If en=1, next state is BLANK with idx=0, cnt=0.
- BLANK:
  - Outputs off; scan_idx=idx.
  - cnt increments.
  - When cnt==BLANK-1, next state is SHOW.
- SHOW:
  - dig_sel[idx]=0 and all other bits 1; bcd=cur[4*idx+:4].
  - cnt increments.
  - When cnt==DIV-1: cnt<=0 and next state is BLANK.
    - If idx==NDIG-1: idx<=0, frame wrap (commit plus frame_done=1 on the next cycle).
    - Otherwise idx<=idx+1.
- Slot period is exactly DIV cycles: BLANK cycles off, DIV-BLANK cycles on. Frame period is NDIG*DIV cycles.
- en=0 in any state: next state is IDLE, with idx=0 and cnt=0. pend and pend_v are retained, and handshakes still complete.
- Codes above 9 pass through unchanged; the decoder blanks them.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - During SHOW, digit idx is suppressed if idx>0 and all cur digits at indices ≥ idx are zero.
  - A suppressed digit drives bcd=4'hF and dig_sel all 1, while slot timing is unchanged.
  - Digit 0 is never suppressed.
- Undefined: every digit shows its raw code.

Test Plan (NDIG=4, DIV=8, BLANK=2 unless noted):
- Reset asserted mid-SHOW → same-cycle dig_sel=4'b1111, bcd=4'hF, load_ready=1, scan_idx=0; after release with en=0, outputs stay off.
- Load 16'h1234 with en=0, then raise en → 2 off cycles, then 6 cycles of dig_sel=1110/bcd=4, then slots showing 3, 2, 1 on 1101, 1011, 0111. frame_done pulses once, 32 cycles after the first BLANK cycle.
- Load 16'h5678 mid-frame while showing 16'h1234 → current frame finishes showing 1234; frame after wrap shows 8,7,6,5; load_ready is 0 from acceptance until the cycle after the wrap.
- Hold load_valid with 16'hAAAA then 16'h9999 back-to-back → second word stalls (load_ready=0) until the first commits; neither word is dropped; both appear in order on consecutive-or-later frames.
- Drop en during slot idx=2 → next cycle all off, scan_idx=0; re-raising en restarts at digit 0 with BLANK; a pending word commits on re-entry.
- With LEADING_ZERO_BLANK_EN, load 16'h0050 → slots 3 and 2 off, slot 1 bcd=5, slot 0 bcd=0. Load 16'h0000 → only slot 0 lit with bcd=0. Without the macro → all four digits lit.
